// File: rtl/bc.sv
// Control FSM for the polynomial datapath bo: sequences x load and the four
// Horner steps (s=a*x; s+=b; s*=x; s+=c) behind a start/busy/done handshake.
module bc #(
  parameter logic H_MUL = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inicio,
  output logic       LX,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       H,
  output logic       LS,
  output logic       LH,
  output logic       ocupado,
  output logic       pronto
);

  localparam int unsigned SW = 3;

  typedef enum logic [SW-1:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    MUL_AX = 3'd2,
    ADD_B  = 3'd3,
    MUL_X  = 3'd4,
    ADD_C  = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Plain vector so the unused code 7 remains representable and recoverable.
  logic [SW-1:0] state_q;
  state_t        state_d;

  logic       lx_d, h_d, ls_d, lh_d, ocupado_d, pronto_d;
  logic [1:0] m0_d, m1_d, m2_d;

  // Next state, plus the control word of the state being entered so the
  // output registers present the Moore decode of the state register.
  always_comb begin
    state_d   = IDLE;
    lx_d      = 1'b0;
    m0_d      = 2'd0;
    m1_d      = 2'd0;
    m2_d      = 2'd0;
    h_d       = ~H_MUL;
    ls_d      = 1'b0;
    lh_d      = 1'b0;
    ocupado_d = 1'b0;
    pronto_d  = 1'b0;

    case (state_q)
      IDLE:    state_d = inicio ? LOAD_X : IDLE;
      LOAD_X:  state_d = MUL_AX;
      MUL_AX:  state_d = ADD_B;
      ADD_B:   state_d = MUL_X;
      MUL_X:   state_d = ADD_C;
      ADD_C:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      LOAD_X: lx_d = 1'b1;
      MUL_AX: begin
        h_d  = H_MUL;
        ls_d = 1'b1;
      end
      ADD_B: begin
        m0_d = 2'd2;
        m1_d = 2'd2;
        m2_d = 2'd1;
        ls_d = 1'b1;
      end
      MUL_X: begin
        m1_d = 2'd2;
        h_d  = H_MUL;
        ls_d = 1'b1;
      end
      ADD_C: begin
        m0_d = 2'd3;
        m1_d = 2'd2;
        m2_d = 2'd1;
        ls_d = 1'b1;
      end
      DONE:    pronto_d = 1'b1;
      default: ;
    endcase

    ocupado_d = (state_d != IDLE);
  end

  // State and control-word registers; reset forces the idle word.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      LX      <= 1'b0;
      M0      <= 2'd0;
      M1      <= 2'd0;
      M2      <= 2'd0;
      H       <= ~H_MUL;
      LS      <= 1'b0;
      LH      <= 1'b0;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      state_q <= state_d;
      LX      <= lx_d;
      M0      <= m0_d;
      M1      <= m1_d;
      M2      <= m2_d;
      H       <= h_d;
      LS      <= ls_d;
      LH      <= lh_d;
      ocupado <= ocupado_d;
      pronto  <= pronto_d;
    end
  end

endmodule
